// File: rtl/apb_mem_pkg.sv
// rtl/apb_mem_pkg.sv - shared defaults, FSM state type and wait-counter width for the APB memory slave
package apb_mem_pkg;

  localparam int DATA_W_DEFAULT = 21;
  localparam int ADDR_W_DEFAULT = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_mem_array.sv
// rtl/apb_mem_array.sv - DEPTH x DATA_W word store with per-word valid bits, one write port, one registered read port
module apb_mem_array #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;

  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic             rd_in_range;

  assign widx        = wr_addr[IDX_W-1:0];
  assign ridx        = rd_addr[IDX_W-1:0];
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

  // Data words carry no reset; the valid bitmap alone decides whether a word reads back as zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[widx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        valid[widx] <= 1'b1;
      end
      if (rd_en) begin
        rd_data <= (rd_in_range && valid[ridx]) ? mem[ridx] : '0;
      end
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB memory slave: transfer FSM, wait-state counter, address check and registered response
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L = CNT_W'(WAIT_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              capture;
  logic              complete;

  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              x_write;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_data;
  logic              oob;
  logic              wr_en;
  logic              rd_en;

  // The SETUP cycle is recognised on the bus itself, so with no wait states the
  // transfer completes on that edge and PREADY is already high in the first ACCESS cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            state_next = SETUP;
            cnt_next   = WAIT_L;
          end
        end
      end
      SETUP: begin
        state_next = ACCESS;
        cnt_next   = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign x_write = capture ? PWRITE : write_q;
  assign x_addr  = capture ? PADDR  : addr_q;
  assign x_data  = capture ? PWDATA : data_q;
  assign oob     = {1'b0, x_addr} >= DEPTH_L;

  // Error responses also pass through the read port so PRDATA is forced to zero.
  assign wr_en = complete && x_write && !oob;
  assign rd_en = complete && (!x_write || oob);

  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        write_q <= PWRITE;
        addr_q  <= PADDR;
        data_q  <= PWDATA;
      end
      PREADY  <= complete;
      PSLVERR <= complete && oob;
    end
  end

  apb_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (PRESETn),
    .wr_en   (wr_en),
    .wr_addr (x_addr),
    .wr_data (x_data),
    .rd_en   (rd_en),
    .rd_addr (x_addr),
    .rd_data (PRDATA)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - self-checking bench for apb_mem_slave (DEPTH=256/WAIT=0 and DEPTH=128/WAIT=3 instances)
module tb_apb_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        psel0, psel1;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [20:0] pwdata;
  logic [20:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int checks = 0;
  int errors = 0;

  logic [20:0] m0 [256];
  logic [20:0] m1 [256];
  bit          v0 [256];
  bit          v1 [256];

  apb_mem_slave #(.DATA_W(21), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_mem_slave #(.DATA_W(21), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .PRESETn(rst_n), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic cur_pready(input int s);
    return (s == 0) ? pready0 : pready1;
  endfunction

  function automatic logic cur_slverr(input int s);
    return (s == 0) ? pslverr0 : pslverr1;
  endfunction

  function automatic logic [20:0] cur_prdata(input int s);
    return (s == 0) ? prdata0 : prdata1;
  endfunction

  // Reference: instance 1 implements 128 words, instance 0 all 256; latency is 2 + wait states.
  function automatic bit ref_err(input int s, input logic [7:0] a);
    return (s == 1) && (a >= 8'd128);
  endfunction

  function automatic int ref_lat(input int s);
    return (s == 0) ? 2 : 5;
  endfunction

  function automatic logic [20:0] ref_read(input int s, input logic [7:0] a);
    if (ref_err(s, a)) return 21'd0;
    if (s == 0) return v0[a] ? m0[a] : 21'd0;
    return v1[a] ? m1[a] : 21'd0;
  endfunction

  task automatic model_write(input int s, input logic [7:0] a, input logic [20:0] d);
    if (!ref_err(s, a)) begin
      if (s == 0) begin m0[a] = d; v0[a] = 1'b1; end
      else        begin m1[a] = d; v1[a] = 1'b1; end
    end
  endtask

  task automatic apply_reset;
    psel0 = 0; psel1 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 256; i++) begin v0[i] = 0; v1[i] = 0; end
  endtask

  task automatic bus_idle;
    @(posedge clk); #1;
    psel0 = 0; psel1 = 0; penable = 0;
  endtask

  // One full transfer; lat counts cycles from SETUP to PREADY inclusive (0 = timed out).
  task automatic xfer(input int s, input bit w, input logic [7:0] a, input logic [20:0] d,
                      output logic [20:0] rd, output bit er, output int lat, output bit stray);
    @(posedge clk); #1;
    psel0 = (s == 0); psel1 = (s == 1);
    penable = 0; pwrite = w; paddr = a; pwdata = d;
    lat = 0; stray = 0; rd = '0; er = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (cur_pready(s)) begin
        lat = c; rd = cur_prdata(s); er = cur_slverr(s);
        break;
      end
      if (cur_slverr(s)) stray = 1;
      @(posedge clk); #1;
      penable = 1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (pready0 !== 1'b0)   begin errors++; $display("FAIL reset_pready0 got %b exp 0", pready0); end
    checks++; if (pslverr0 !== 1'b0)  begin errors++; $display("FAIL reset_pslverr0 got %b exp 0", pslverr0); end
    checks++; if (prdata0 !== 21'd0)  begin errors++; $display("FAIL reset_prdata0 got %0h exp 0", prdata0); end
    checks++; if (pready1 !== 1'b0)   begin errors++; $display("FAIL reset_pready1 got %b exp 0", pready1); end
    checks++; if (pslverr1 !== 1'b0)  begin errors++; $display("FAIL reset_pslverr1 got %b exp 0", pslverr1); end
    checks++; if (prdata1 !== 21'd0)  begin errors++; $display("FAIL reset_prdata1 got %0h exp 0", prdata1); end
  endtask

  task automatic test_unwritten;
    logic [20:0] rd; bit er; int lat; bit st;
    xfer(0, 0, 8'h19, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (rd !== 21'd0) begin errors++; $display("FAIL unwritten_data got %0h exp 0", rd); end
    checks++; if (er !== 1'b0)  begin errors++; $display("FAIL unwritten_err got %b exp 0", er); end
  endtask

  task automatic test_basic;
    logic [20:0] rd; bit er; int lat; bit st;
    xfer(0, 1, 8'h12, 21'd10, rd, er, lat, st);
    model_write(0, 8'h12, 21'd10);
    bus_idle();
    checks++; if (lat !== 2)   begin errors++; $display("FAIL basic_wr_lat got %0d exp 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b exp 0", er); end
    xfer(0, 0, 8'h12, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (lat !== 2)      begin errors++; $display("FAIL basic_rd_lat got %0d exp 2", lat); end
    checks++; if (rd !== 21'd10)  begin errors++; $display("FAIL basic_rd_data got %0d exp 10", rd); end
    checks++; if (er !== 1'b0)    begin errors++; $display("FAIL basic_rd_err got %b exp 0", er); end
  endtask

  task automatic test_range;
    logic [20:0] rd; bit er; int lat; bit st;
    xfer(1, 1, 8'h80, 21'h1FFFFF, rd, er, lat, st);
    model_write(1, 8'h80, 21'h1FFFFF);
    bus_idle();
    checks++; if (er !== 1'b1)   begin errors++; $display("FAIL range_wr_err got %b exp 1", er); end
    checks++; if (rd !== 21'd0)  begin errors++; $display("FAIL range_wr_data got %0h exp 0", rd); end
    xfer(1, 0, 8'h80, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (er !== 1'b1)   begin errors++; $display("FAIL range_rd_err got %b exp 1", er); end
    checks++; if (rd !== 21'd0)  begin errors++; $display("FAIL range_rd_data got %0h exp 0", rd); end
    checks++; if (st !== 1'b0)   begin errors++; $display("FAIL range_stray_slverr got %b exp 0", st); end
    xfer(1, 0, 8'h00, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (rd !== ref_read(1, 8'h00)) begin errors++; $display("FAIL range_alias got %0h exp %0h", rd, ref_read(1, 8'h00)); end
    checks++; if (er !== 1'b0)   begin errors++; $display("FAIL range_alias_err got %b exp 0", er); end
  endtask

  task automatic test_wait;
    logic [20:0] rd; bit er; int lat; bit st;
    xfer(1, 1, 8'h05, 21'd27, rd, er, lat, st);
    model_write(1, 8'h05, 21'd27);
    bus_idle();
    @(negedge clk);
    checks++; if (lat !== 5)        begin errors++; $display("FAIL wait_wr_lat got %0d exp 5", lat); end
    checks++; if (pready1 !== 1'b0) begin errors++; $display("FAIL wait_pulse_width got %b exp 0", pready1); end
    xfer(1, 0, 8'h05, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (lat !== 5)        begin errors++; $display("FAIL wait_rd_lat got %0d exp 5", lat); end
    checks++; if (rd !== 21'd27)    begin errors++; $display("FAIL wait_rd_data got %0d exp 27", rd); end
  endtask

  task automatic test_abort;
    logic [20:0] rd; bit er; int lat; bit st; bit seen;
    seen = 0;
    @(posedge clk); #1;
    psel1 = 1; penable = 0; pwrite = 1; paddr = 8'h07; pwdata = 21'd99;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel1 = 0; penable = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready1) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready got %b exp 0", seen); end
    xfer(1, 0, 8'h07, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (lat !== 5)   begin errors++; $display("FAIL abort_next_lat got %0d exp 5", lat); end
    checks++; if (rd !== ref_read(1, 8'h07)) begin errors++; $display("FAIL abort_rd_data got %0d exp %0d", rd, ref_read(1, 8'h07)); end
  endtask

  task automatic test_back_to_back;
    logic [20:0] rd; bit er; int lat; bit st;
    logic [20:0] d;
    d = 21'($urandom);
    xfer(0, 1, 8'h44, d, rd, er, lat, st);
    model_write(0, 8'h44, d);
    xfer(0, 0, 8'h44, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_rd_lat got %0d exp 2", lat); end
    checks++; if (rd !== d)  begin errors++; $display("FAIL b2b_rd_data got %0h exp %0h", rd, d); end
  endtask

  task automatic test_reset_mid;
    logic [20:0] rd; bit er; int lat; bit st;
    xfer(1, 1, 8'h33, 21'd5, rd, er, lat, st);
    model_write(1, 8'h33, 21'd5);
    xfer(1, 0, 8'h33, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (rd !== 21'd5) begin errors++; $display("FAIL rstmid_pre_data got %0d exp 5", rd); end
    @(posedge clk); #1;
    psel1 = 1; penable = 0; pwrite = 0; paddr = 8'h33;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    checks++; if (prdata1 !== 21'd0) begin errors++; $display("FAIL rstmid_prdata got %0h exp 0", prdata1); end
    checks++; if (pready1 !== 1'b0)  begin errors++; $display("FAIL rstmid_pready got %b exp 0", pready1); end
    checks++; if (pslverr1 !== 1'b0) begin errors++; $display("FAIL rstmid_pslverr got %b exp 0", pslverr1); end
    @(posedge clk); #1;
    psel1 = 0; penable = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 256; i++) begin v0[i] = 0; v1[i] = 0; end
    xfer(1, 0, 8'h33, 21'h0, rd, er, lat, st);
    bus_idle();
    checks++; if (rd !== 21'd0) begin errors++; $display("FAIL rstmid_post_data got %0d exp 0", rd); end
    checks++; if (lat !== 5)    begin errors++; $display("FAIL rstmid_post_lat got %0d exp 5", lat); end
  endtask

  task automatic test_random;
    logic [20:0] rd; bit er; int lat; bit st;
    int s; bit w; logic [7:0] a; logic [20:0] d;
    for (int n = 0; n < 80; n++) begin
      s = int'($urandom_range(1, 0));
      w = 1'($urandom_range(1, 0));
      a = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 120)) : 8'($urandom_range(15, 0));
      d = 21'($urandom);
      xfer(s, w, a, d, rd, er, lat, st);
      checks++; if (lat !== ref_lat(s)) begin errors++; $display("FAIL rand_lat[%0d] got %0d exp %0d", n, lat, ref_lat(s)); end
      checks++; if (er !== ref_err(s, a)) begin errors++; $display("FAIL rand_err[%0d] got %b exp %b", n, er, ref_err(s, a)); end
      if (!w || ref_err(s, a)) begin
        checks++;
        if (rd !== ref_read(s, a)) begin
          errors++; $display("FAIL rand_data[%0d] dut%0d addr %0h got %0h exp %0h", n, s, a, rd, ref_read(s, a));
        end
      end
      if (w) model_write(s, a, d);
      if ($urandom_range(1, 0) == 0) bus_idle();
    end
    bus_idle();
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_unwritten();
    test_basic();
    test_range();
    test_wait();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
